// File: rtl/bp_me_mem_cmd_router.sv
`default_nettype none
// ============================================================================
//  Module      : bp_me_mem_cmd_router
//  Description : N-target memory-command router for a CCE mem_cmd/mem_resp
//                port. Commands are decoded by address to one local target
//                (zero-latency pass-through). The target ID of every accepted
//                command is recorded in an order-tracking FIFO so responses are
//                handed back to the CCE strictly in command order, even when
//                targets answer out of order.
//  Revision    : 1.0  initial release
// ============================================================================
module bp_me_mem_cmd_router #(
    parameter int num_tgt_p          = 2,
    parameter int msg_width_p        = 128,
    parameter int paddr_width_p      = 40,
    parameter logic [paddr_width_p-1:0] local_limit_p = paddr_width_p'(32'h8000_0000),
    parameter int dev_offset_p       = 20,
    parameter int dev_width_p        = 4,
    parameter int default_tgt_p      = 0,
    parameter logic [4*(2**dev_width_p)-1:0] dev_map_p =
        {{(4*(2**dev_width_p)-8){1'b0}}, 8'h10},
    parameter int max_outstanding_p  = 8
) (
    input  logic                                 clk_i,
    input  logic                                 reset_n_i,

    input  logic [msg_width_p-1:0]               cmd_i,
    input  logic [paddr_width_p-1:0]             cmd_addr_i,
    input  logic                                 cmd_v_i,
    output logic                                 cmd_ready_o,

    output logic [msg_width_p-1:0]               resp_o,
    output logic                                 resp_v_o,
    input  logic                                 resp_yumi_i,

    output logic [num_tgt_p*msg_width_p-1:0]     tgt_cmd_o,
    output logic [num_tgt_p-1:0]                 tgt_cmd_v_o,
    input  logic [num_tgt_p-1:0]                 tgt_cmd_ready_i,

    input  logic [num_tgt_p*msg_width_p-1:0]     tgt_resp_i,
    input  logic [num_tgt_p-1:0]                 tgt_resp_v_i,
    output logic [num_tgt_p-1:0]                 tgt_resp_yumi_o,

    output logic [$clog2(max_outstanding_p+1)-1:0] outstanding_o,
    output logic                                 unmapped_o
);

    localparam int c_tgt_w = $clog2(num_tgt_p);
    localparam int c_ptr_w = $clog2(max_outstanding_p);
    localparam int c_cnt_w = $clog2(max_outstanding_p + 1);

    localparam logic [c_cnt_w-1:0] c_depth       = c_cnt_w'(max_outstanding_p);
    localparam logic [c_tgt_w-1:0] c_default_tgt = c_tgt_w'(default_tgt_p);

    // ------------------------------------------------------------------------
    // Order-tracking FIFO state
    // ------------------------------------------------------------------------
    logic [c_tgt_w-1:0] fifo_q [max_outstanding_p];
    logic [c_ptr_w-1:0] wr_ptr_q, wr_ptr_d;
    logic [c_ptr_w-1:0] rd_ptr_q, rd_ptr_d;
    logic [c_cnt_w-1:0] count_q,  count_d;

    logic               w_full;
    logic               w_empty;
    logic [c_tgt_w-1:0] w_head;

    // ------------------------------------------------------------------------
    // Decode / handshake wires
    // ------------------------------------------------------------------------
    logic [dev_width_p-1:0] w_dev_field;
    logic [3:0]             w_map_entry;
    logic [c_tgt_w-1:0]     w_tgt_sel;
    logic                   w_unmapped;
    logic                   w_sel_ready;
    logic                   w_cmd_fire_v;
    logic                   w_push;
    logic                   w_head_v;
    logic                   w_pop;

    assign w_full  = (count_q == c_depth);
    assign w_empty = (count_q == '0);
    assign w_head  = fifo_q[rd_ptr_q];

    // Address decode: non-local goes to the default target; local addresses
    // look up the device map and fall back to the default when unmapped.
    always_comb begin
        w_dev_field = cmd_addr_i[dev_offset_p +: dev_width_p];
        w_map_entry = dev_map_p[32'(w_dev_field)*4 +: 4];
        w_tgt_sel   = c_default_tgt;
        w_unmapped  = 1'b0;
        if (cmd_addr_i < local_limit_p) begin
            if (32'(w_map_entry) < num_tgt_p) begin
                w_tgt_sel = w_map_entry[c_tgt_w-1:0];
            end else begin
                w_unmapped = 1'b1;
            end
        end
    end

    // Select the ready of the decoded target.
    always_comb begin
        w_sel_ready = 1'b0;
        for (int i = 0; i < num_tgt_p; i++) begin
            if (w_tgt_sel == c_tgt_w'(i)) begin
                w_sel_ready = tgt_cmd_ready_i[i];
            end
        end
    end

    // Select the response and valid of the target at the FIFO head.
    always_comb begin
        w_head_v = 1'b0;
        resp_o   = '0;
        for (int i = 0; i < num_tgt_p; i++) begin
            if (w_head == c_tgt_w'(i)) begin
                w_head_v = tgt_resp_v_i[i];
                resp_o   = tgt_resp_i[i*msg_width_p +: msg_width_p];
            end
        end
    end

    // Ready never depends on resp_yumi_i: a full FIFO blocks pushes even if
    // the head is popped in the same cycle. Reset forces the handshakes low.
    assign w_cmd_fire_v = reset_n_i & cmd_v_i & ~w_full;
    assign cmd_ready_o  = reset_n_i & w_sel_ready & ~w_full;
    assign w_push       = cmd_v_i & cmd_ready_o;
    assign unmapped_o   = w_push & w_unmapped;

    assign resp_v_o     = reset_n_i & ~w_empty & w_head_v;
    assign w_pop        = resp_yumi_i & resp_v_o;

    assign outstanding_o = count_q;

    // Per-target command broadcast, one-hot valid, and head-only consume.
    for (genvar g = 0; g < num_tgt_p; g++) begin : g_tgt
        assign tgt_cmd_o[g*msg_width_p +: msg_width_p] = cmd_i;
        assign tgt_cmd_v_o[g]     = w_cmd_fire_v & (w_tgt_sel == c_tgt_w'(g));
        assign tgt_resp_yumi_o[g] = w_pop & (w_head == c_tgt_w'(g));
    end

    // FIFO pointer and occupancy next-state; pointers wrap naturally since
    // the depth is a power of two.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (w_push) begin
            wr_ptr_d = wr_ptr_q + c_ptr_w'(1);
        end
        if (w_pop) begin
            rd_ptr_d = rd_ptr_q + c_ptr_w'(1);
        end
        if (w_push && !w_pop) begin
            count_d = count_q + c_cnt_w'(1);
        end else if (!w_push && w_pop) begin
            count_d = count_q - c_cnt_w'(1);
        end
    end

    // FIFO state registers; asynchronous reset empties the FIFO at once.
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            for (int i = 0; i < max_outstanding_p; i++) begin
                fifo_q[i] <= '0;
            end
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            if (w_push) begin
                fifo_q[wr_ptr_q] <= w_tgt_sel;
            end
        end
    end

`ifndef SYNTHESIS
    // Protocol sanity: one-hot command valid, consume only when valid,
    // never push into a full FIFO.
    always @(posedge clk_i) begin
        if (reset_n_i) begin
            assert ($onehot0(tgt_cmd_v_o));
            assert (!resp_yumi_i || resp_v_o);
            assert (!(w_push && w_full));
        end
    end
`endif

endmodule
`default_nettype wire

// File: tb/tb_bp_me_mem_cmd_router.sv
`default_nettype none
// ============================================================================
//  Module      : tb_bp_me_mem_cmd_router
//  Description : Self-checking bench for bp_me_mem_cmd_router with a
//                queue-based reference model of command order and routing.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_bp_me_mem_cmd_router;

    localparam int NT    = 2;
    localparam int MW    = 128;
    localparam int AW    = 40;
    localparam int DEPTH = 8;
    localparam logic [AW-1:0] LIMIT = 40'h80_0000_0000 >> 8;   // 0x8000_0000
    localparam logic [63:0]   MAP   = 64'h0000_0000_0000_F010;  // dev1->1, dev3->unmapped

    logic                 clk_i;
    logic                 reset_n_i;
    logic [MW-1:0]        cmd_i;
    logic [AW-1:0]        cmd_addr_i;
    logic                 cmd_v_i;
    logic                 cmd_ready_o;
    logic [MW-1:0]        resp_o;
    logic                 resp_v_o;
    logic                 resp_yumi_i;
    logic [NT*MW-1:0]     tgt_cmd_o;
    logic [NT-1:0]        tgt_cmd_v_o;
    logic [NT-1:0]        tgt_cmd_ready_i;
    logic [NT*MW-1:0]     tgt_resp_i;
    logic [NT-1:0]        tgt_resp_v_i;
    logic [NT-1:0]        tgt_resp_yumi_o;
    logic [3:0]           outstanding_o;
    logic                 unmapped_o;

    int errors = 0;
    int checks = 0;
    int q[$];   // model: target IDs of issued, not yet returned commands

    bp_me_mem_cmd_router #(
        .num_tgt_p        (NT),
        .msg_width_p      (MW),
        .paddr_width_p    (AW),
        .local_limit_p    (LIMIT),
        .dev_offset_p     (20),
        .dev_width_p      (4),
        .default_tgt_p    (0),
        .dev_map_p        (MAP),
        .max_outstanding_p(DEPTH)
    ) dut (
        .clk_i           (clk_i),
        .reset_n_i       (reset_n_i),
        .cmd_i           (cmd_i),
        .cmd_addr_i      (cmd_addr_i),
        .cmd_v_i         (cmd_v_i),
        .cmd_ready_o     (cmd_ready_o),
        .resp_o          (resp_o),
        .resp_v_o        (resp_v_o),
        .resp_yumi_i     (resp_yumi_i),
        .tgt_cmd_o       (tgt_cmd_o),
        .tgt_cmd_v_o     (tgt_cmd_v_o),
        .tgt_cmd_ready_i (tgt_cmd_ready_i),
        .tgt_resp_i      (tgt_resp_i),
        .tgt_resp_v_i    (tgt_resp_v_i),
        .tgt_resp_yumi_o (tgt_resp_yumi_o),
        .outstanding_o   (outstanding_o),
        .unmapped_o      (unmapped_o)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1, "watchdog");
    end

    // ---------------- reference model ----------------
    function automatic int map_nibble(input logic [AW-1:0] a);
        int d;
        d = int'((a >> 20) % 40'd16);
        return int'((MAP >> (d * 4)) % 64'd16);
    endfunction

    function automatic int ref_route(input logic [AW-1:0] a);
        if (a >= 40'h0080_0000_00) return 0;
        if (map_nibble(a) >= NT) return 0;
        return map_nibble(a);
    endfunction

    function automatic bit ref_unmapped(input logic [AW-1:0] a);
        return (a < 40'h0080_0000_00) && (map_nibble(a) >= NT);
    endfunction

    function automatic bit m_full();
        return q.size() == DEPTH;
    endfunction

    function automatic bit m_ready();
        return !m_full() && tgt_cmd_ready_i[ref_route(cmd_addr_i)];
    endfunction

    function automatic bit m_resp_v();
        return (q.size() > 0) && tgt_resp_v_i[q[0]];
    endfunction

    function automatic logic [MW-1:0] m_resp();
        if (q.size() == 0) return '0;
        return tgt_resp_i[q[0]*MW +: MW];
    endfunction

    function automatic logic [AW-1:0] rand_addr();
        if ($urandom_range(0, 3) == 0) return 40'h0080_0000_00 + 40'($urandom);
        return {9'h0, 7'($urandom), 4'($urandom), 20'($urandom)};
    endfunction

    function automatic logic [MW-1:0] rand_msg();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    // Commit one clock edge into the model, then return at the falling edge.
    task automatic advance();
        bit push, pop;
        int sel;
        push = reset_n_i && cmd_v_i && m_ready();
        pop  = reset_n_i && resp_yumi_i && m_resp_v();
        sel  = ref_route(cmd_addr_i);
        @(posedge clk_i);
        if (pop)  void'(q.pop_front());
        if (push) q.push_back(sel);
        @(negedge clk_i);
    endtask

    task automatic idle();
        cmd_v_i      = 1'b0;
        resp_yumi_i  = 1'b0;
        tgt_resp_v_i = '0;
        tgt_cmd_ready_i = '1;
    endtask

    task automatic drain();
        cmd_v_i = 1'b0;
        tgt_resp_v_i = '1;
        for (int n = 0; n < 4 * DEPTH && q.size() > 0; n++) begin
            resp_yumi_i = m_resp_v();
            #1;
            advance();
        end
        idle();
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        reset_n_i = 1'b0;
        cmd_i = rand_msg(); cmd_addr_i = 40'h0010_0000; cmd_v_i = 1'b1;
        tgt_cmd_ready_i = '1; tgt_resp_v_i = '1; tgt_resp_i = {rand_msg(), rand_msg()};
        resp_yumi_i = 1'b0;
        repeat (3) @(negedge clk_i);
        #1;
        checks++; if (cmd_ready_o !== 1'b0) begin errors++; $display("FAIL reset_cmd_ready: got %b want 0", cmd_ready_o); end
        checks++; if (tgt_cmd_v_o !== 2'b00) begin errors++; $display("FAIL reset_tgt_cmd_v: got %b want 00", tgt_cmd_v_o); end
        checks++; if (resp_v_o !== 1'b0) begin errors++; $display("FAIL reset_resp_v: got %b want 0", resp_v_o); end
        checks++; if (outstanding_o !== 4'd0) begin errors++; $display("FAIL reset_outstanding: got %0d want 0", outstanding_o); end
        checks++; if (unmapped_o !== 1'b0) begin errors++; $display("FAIL reset_unmapped: got %b want 0", unmapped_o); end
        checks++; if (tgt_resp_yumi_o !== 2'b00) begin errors++; $display("FAIL reset_yumi: got %b want 00", tgt_resp_yumi_o); end
        @(negedge clk_i);
        reset_n_i = 1'b1;
        idle();
        q.delete();
        @(negedge clk_i);
    endtask

    task automatic test_route();
        logic [AW-1:0] addrs [2];
        logic [1:0]    tv    [2];
        logic [MW-1:0] rdat;
        addrs[0] = 40'h0080_0010_00; tv[0] = 2'b01;
        addrs[1] = 40'h0000_1000_00; tv[1] = 2'b10;
        for (int i = 0; i < 2; i++) begin
            cmd_addr_i = addrs[i]; cmd_i = rand_msg(); cmd_v_i = 1'b1; tgt_cmd_ready_i = '1;
            #1;
            checks++; if (tgt_cmd_v_o !== tv[i]) begin errors++; $display("FAIL route_tgt_v[%0d]: got %b want %b", i, tgt_cmd_v_o, tv[i]); end
            checks++; if (cmd_ready_o !== 1'b1) begin errors++; $display("FAIL route_ready[%0d]: got %b want 1", i, cmd_ready_o); end
            advance();
            cmd_v_i = 1'b0;
            rdat = rand_msg();
            tgt_resp_i = '0;
            tgt_resp_i[i*MW +: MW] = rdat;
            tgt_resp_v_i = tv[i]; resp_yumi_i = 1'b1;
            #1;
            checks++; if (outstanding_o !== 4'd1) begin errors++; $display("FAIL route_outst1[%0d]: got %0d want 1", i, outstanding_o); end
            checks++; if (resp_v_o !== 1'b1) begin errors++; $display("FAIL route_resp_v[%0d]: got %b want 1", i, resp_v_o); end
            checks++; if (resp_o !== rdat) begin errors++; $display("FAIL route_resp[%0d]: got %h want %h", i, resp_o, rdat); end
            checks++; if (tgt_resp_yumi_o !== tv[i]) begin errors++; $display("FAIL route_yumi[%0d]: got %b want %b", i, tgt_resp_yumi_o, tv[i]); end
            advance();
            idle();
            #1;
            checks++; if (outstanding_o !== 4'd0) begin errors++; $display("FAIL route_outst0[%0d]: got %0d want 0", i, outstanding_o); end
        end
    endtask

    task automatic test_reorder();
        logic [MW-1:0] d0, d1;
        d0 = rand_msg(); d1 = rand_msg();
        tgt_resp_i = {d1, d0};
        cmd_addr_i = 40'h0080_0010_00; cmd_v_i = 1'b1; #1; advance();
        cmd_addr_i = 40'h0000_1000_00; #1; advance();
        cmd_v_i = 1'b0; tgt_resp_v_i = 2'b10; resp_yumi_i = 1'b0;
        #1;
        checks++; if (resp_v_o !== 1'b0) begin errors++; $display("FAIL reorder_hold_v: got %b want 0", resp_v_o); end
        checks++; if (tgt_resp_yumi_o !== 2'b00) begin errors++; $display("FAIL reorder_hold_yumi: got %b want 00", tgt_resp_yumi_o); end
        advance();
        #1;
        checks++; if (resp_v_o !== 1'b0) begin errors++; $display("FAIL reorder_hold_v2: got %b want 0", resp_v_o); end
        tgt_resp_v_i = 2'b11; resp_yumi_i = 1'b1;
        #1;
        checks++; if (resp_v_o !== 1'b1) begin errors++; $display("FAIL reorder_first_v: got %b want 1", resp_v_o); end
        checks++; if (resp_o !== d0) begin errors++; $display("FAIL reorder_first_data: got %h want %h", resp_o, d0); end
        checks++; if (tgt_resp_yumi_o !== 2'b01) begin errors++; $display("FAIL reorder_first_yumi: got %b want 01", tgt_resp_yumi_o); end
        advance();
        #1;
        checks++; if (resp_o !== d1) begin errors++; $display("FAIL reorder_second_data: got %h want %h", resp_o, d1); end
        checks++; if (tgt_resp_yumi_o !== 2'b10) begin errors++; $display("FAIL reorder_second_yumi: got %b want 10", tgt_resp_yumi_o); end
        checks++; if (outstanding_o !== 4'd1) begin errors++; $display("FAIL reorder_outst: got %0d want 1", outstanding_o); end
        advance();
        idle();
        #1;
        checks++; if (outstanding_o !== 4'd0) begin errors++; $display("FAIL reorder_empty: got %0d want 0", outstanding_o); end
    endtask

    task automatic test_full();
        for (int i = 0; i < DEPTH; i++) begin
            cmd_addr_i = rand_addr(); cmd_i = rand_msg(); cmd_v_i = 1'b1;
            #1;
            checks++; if (cmd_ready_o !== 1'b1) begin errors++; $display("FAIL full_fill_ready[%0d]: got %b want 1", i, cmd_ready_o); end
            advance();
        end
        cmd_addr_i = rand_addr();
        #1;
        checks++; if (cmd_ready_o !== 1'b0) begin errors++; $display("FAIL full_ninth_ready: got %b want 0", cmd_ready_o); end
        checks++; if (tgt_cmd_v_o !== 2'b00) begin errors++; $display("FAIL full_ninth_v: got %b want 00", tgt_cmd_v_o); end
        checks++; if (outstanding_o !== 4'd8) begin errors++; $display("FAIL full_count: got %0d want 8", outstanding_o); end
        tgt_resp_v_i = 2'b11; tgt_resp_i = {rand_msg(), rand_msg()}; resp_yumi_i = 1'b1;
        #1;
        checks++; if (cmd_ready_o !== 1'b0) begin errors++; $display("FAIL full_pop_ready: got %b want 0", cmd_ready_o); end
        checks++; if (resp_v_o !== 1'b1) begin errors++; $display("FAIL full_pop_v: got %b want 1", resp_v_o); end
        advance();
        resp_yumi_i = 1'b0;
        #1;
        checks++; if (outstanding_o !== 4'd7) begin errors++; $display("FAIL full_after_pop: got %0d want 7", outstanding_o); end
        checks++; if (cmd_ready_o !== 1'b1) begin errors++; $display("FAIL full_ready_again: got %b want 1", cmd_ready_o); end
        advance();
        cmd_v_i = 1'b0;
        #1;
        checks++; if (outstanding_o !== 4'd8) begin errors++; $display("FAIL full_refill: got %0d want 8", outstanding_o); end
        for (int n = 0; n < 2 * DEPTH && q.size() > 0; n++) begin
            tgt_resp_i = {rand_msg(), rand_msg()}; resp_yumi_i = 1'b1;
            #1;
            checks++; if (resp_o !== m_resp()) begin errors++; $display("FAIL full_drain_data[%0d]: got %h want %h", n, resp_o, m_resp()); end
            advance();
        end
        idle();
    endtask

    task automatic test_unmapped();
        cmd_addr_i = 40'h0000_3000_00; cmd_i = rand_msg(); cmd_v_i = 1'b1;
        #1;
        checks++; if (tgt_cmd_v_o !== 2'b01) begin errors++; $display("FAIL unmapped_route: got %b want 01", tgt_cmd_v_o); end
        checks++; if (unmapped_o !== 1'b1) begin errors++; $display("FAIL unmapped_pulse: got %b want 1", unmapped_o); end
        advance();
        cmd_v_i = 1'b0;
        #1;
        checks++; if (unmapped_o !== 1'b0) begin errors++; $display("FAIL unmapped_one_cycle: got %b want 0", unmapped_o); end
        checks++; if (outstanding_o !== 4'd1) begin errors++; $display("FAIL unmapped_outst: got %0d want 1", outstanding_o); end
        drain();
    endtask

    task automatic test_backpressure();
        tgt_cmd_ready_i = 2'b01; cmd_addr_i = 40'h0000_1000_00; cmd_v_i = 1'b1;
        #1;
        checks++; if (cmd_ready_o !== 1'b0) begin errors++; $display("FAIL bp_ready: got %b want 0", cmd_ready_o); end
        checks++; if (tgt_cmd_v_o !== 2'b10) begin errors++; $display("FAIL bp_tgt_v: got %b want 10", tgt_cmd_v_o); end
        advance();
        #1;
        checks++; if (outstanding_o !== 4'd0) begin errors++; $display("FAIL bp_outst: got %0d want 0", outstanding_o); end
        tgt_cmd_ready_i = 2'b11;
        #1;
        checks++; if (cmd_ready_o !== 1'b1) begin errors++; $display("FAIL bp_release: got %b want 1", cmd_ready_o); end
        advance();
        cmd_v_i = 1'b0;
        drain();
    endtask

    task automatic test_reset_mid();
        logic [AW-1:0] a [3];
        a[0] = 40'h0080_0010_00; a[1] = 40'h0000_1000_00; a[2] = 40'h0000_0000_40;
        for (int i = 0; i < 3; i++) begin
            cmd_addr_i = a[i]; cmd_v_i = 1'b1; #1; advance();
        end
        cmd_v_i = 1'b0; tgt_resp_v_i = 2'b11;
        #1;
        checks++; if (outstanding_o !== 4'd3) begin errors++; $display("FAIL rstmid_pre: got %0d want 3", outstanding_o); end
        #2;
        reset_n_i = 1'b0;
        #1;
        q.delete();
        checks++; if (outstanding_o !== 4'd0) begin errors++; $display("FAIL rstmid_outst: got %0d want 0", outstanding_o); end
        checks++; if (resp_v_o !== 1'b0) begin errors++; $display("FAIL rstmid_resp_v: got %b want 0", resp_v_o); end
        @(negedge clk_i);
        reset_n_i = 1'b1;
        #1;
        checks++; if (resp_v_o !== 1'b0) begin errors++; $display("FAIL rstmid_no_forward: got %b want 0", resp_v_o); end
        idle();
    endtask

    task automatic test_random();
        bit            ev, eu;
        logic [1:0]    et, ey;
        for (int c = 0; c < 400; c++) begin
            cmd_v_i         = ($urandom_range(0, 2) != 0);
            cmd_addr_i      = rand_addr();
            cmd_i           = rand_msg();
            tgt_cmd_ready_i = 2'($urandom);
            tgt_resp_i      = {rand_msg(), rand_msg()};
            tgt_resp_v_i    = 2'($urandom);
            resp_yumi_i     = m_resp_v() && ($urandom_range(0, 3) != 0);
            ev = m_resp_v();
            et = (cmd_v_i && !m_full()) ? 2'(1 << ref_route(cmd_addr_i)) : 2'b00;
            ey = (resp_yumi_i && ev) ? 2'(1 << q[0]) : 2'b00;
            eu = cmd_v_i && m_ready() && ref_unmapped(cmd_addr_i);
            #1;
            checks++; if (cmd_ready_o !== m_ready()) begin errors++; $display("FAIL rnd_ready[%0d]: got %b want %b", c, cmd_ready_o, m_ready()); end
            checks++; if (tgt_cmd_v_o !== et) begin errors++; $display("FAIL rnd_tgt_v[%0d]: got %b want %b", c, tgt_cmd_v_o, et); end
            checks++; if (resp_v_o !== ev) begin errors++; $display("FAIL rnd_resp_v[%0d]: got %b want %b", c, resp_v_o, ev); end
            if (ev) begin
                checks++; if (resp_o !== m_resp()) begin errors++; $display("FAIL rnd_resp[%0d]: got %h want %h", c, resp_o, m_resp()); end
            end
            checks++; if (tgt_resp_yumi_o !== ey) begin errors++; $display("FAIL rnd_yumi[%0d]: got %b want %b", c, tgt_resp_yumi_o, ey); end
            checks++; if (unmapped_o !== eu) begin errors++; $display("FAIL rnd_unmapped[%0d]: got %b want %b", c, unmapped_o, eu); end
            checks++; if (outstanding_o !== 4'(q.size())) begin errors++; $display("FAIL rnd_outst[%0d]: got %0d want %0d", c, outstanding_o, q.size()); end
            checks++; if (tgt_cmd_o !== {cmd_i, cmd_i}) begin errors++; $display("FAIL rnd_broadcast[%0d]: got %h want %h", c, tgt_cmd_o, {cmd_i, cmd_i}); end
            advance();
        end
        drain();
        #1;
        checks++; if (outstanding_o !== 4'd0) begin errors++; $display("FAIL rnd_final: got %0d want 0", outstanding_o); end
    endtask

    initial begin
        test_reset();
        test_route();
        test_reorder();
        test_full();
        test_unmapped();
        test_backpressure();
        test_reset_mid();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/bp_me_mem_cmd_router.md
Name: bp_me_mem_cmd_router

Overview:
- Parametrised N-target memory-command router with in-order response return.
- Sits between a CCE's mem_cmd/mem_resp port and its local targets: L2 cache slice, cfg block, CLINT, and future local devices.
- Generalises the fixed 2-way cache/cfg split:
  - configurable target count, decode field, default target and outstanding depth;
  - adds a target-ID tracking FIFO so responses return to the CCE in command order, even when targets answer out of order.

Parameters:
- num_tgt_p, 2, number of downstream targets (2..16).
- msg_width_p, 128, width of one bp_cce_mem_msg_s, passed through opaquely.
- paddr_width_p, 40, physical address width.
- local_limit_p, 32'h8000_0000, addresses below this are local and decoded by device field; addresses at or above go to default_tgt_p.
- dev_offset_p, 20, LSB of device field in address.
- dev_width_p, 4, width of device field.
- default_tgt_p, 0, target for non-local and unmapped addresses.
- dev_map_p, {16{4'd0}} with entry 1 = 1, packed table: device field value d selects target dev_map_p[d*4+:4]; entries >= num_tgt_p mean unmapped.
- max_outstanding_p, 8, depth of order-tracking FIFO (power of two, >= 2).

Ports:
- clk_i  in  1  clock.
- reset_n_i  in  1  reset, asynchronous, active-low.
- cmd_i  in  msg_width_p  command from CCE.
- cmd_addr_i  in  paddr_width_p  address field of cmd_i.
- cmd_v_i  in  1  command valid.
- cmd_ready_o  out  1  command accept (ready/valid).
- resp_o  out  msg_width_p  response to CCE.
- resp_v_o  out  1  response valid.
- resp_yumi_i  in  1  CCE consumes response.
- tgt_cmd_o  out  num_tgt_p*msg_width_p  command broadcast; every slice equals cmd_i.
- tgt_cmd_v_o  out  num_tgt_p  per-target command valid, one-hot or zero.
- tgt_cmd_ready_i  in  num_tgt_p  per-target ready.
- tgt_resp_i  in  num_tgt_p*msg_width_p  per-target responses.
- tgt_resp_v_i  in  num_tgt_p  per-target response valid.
- tgt_resp_yumi_o  out  num_tgt_p  per-target consume, one-hot or zero.
- outstanding_o  out  $clog2(max_outstanding_p+1)  commands issued but not yet returned.
- unmapped_o  out  1  one-cycle pulse when an unmapped local command is accepted.

Behaviour:
- Clock and reset: one clock, clk_i. Reset is asynchronous and active-low on reset_n_i.
- Reset values: FIFO empty; outstanding_o=0; cmd_ready_o=0; resp_v_o=0; tgt_cmd_v_o=0; tgt_resp_yumi_o=0; unmapped_o=0.
- Decode (combinational) to tgt_sel:
  - cmd_addr_i >= local_limit_p -> default_tgt_p.
  - Otherwise d = cmd_addr_i[dev_offset_p+:dev_width_p]; t = dev_map_p[d].
  - t < num_tgt_p -> t.
  - t >= num_tgt_p -> default_tgt_p, and unmapped_o pulses on acceptance.
- Command path:
  - tgt_cmd_v_o[tgt_sel] = cmd_v_i & ~fifo_full.
  - cmd_ready_o = tgt_cmd_ready_i[tgt_sel] & ~fifo_full.
  - Accept = cmd_v_i & cmd_ready_o. On accept, push tgt_sel into FIFO.
  - Zero added latency: a combinational pass-through.
  - No full-bypass: when full, a same-cycle pop does not enable a push. This keeps cmd_ready_o free of any resp_yumi_i path.
- Response path:
  - Only the target at the FIFO head is eligible. h = head.
  - resp_v_o = ~fifo_empty & tgt_resp_v_i[h].
  - resp_o = tgt_resp_i slice h.
  - tgt_resp_yumi_o[h] = resp_yumi_i; all other bits 0.
  - resp_yumi_i pops the FIFO.
  - Responses from non-head targets are held at the target (not consumed) until that target reaches the head.
  - Response with FIFO empty: ignored, resp_v_o=0.
- Counters:
  - outstanding_o = FIFO occupancy.
  - Simultaneous push and pop (not full): occupancy unchanged, pointers both advance.
  - Pointers wrap modulo max_outstanding_p.
- Assertions (sim only): one-hot tgt_cmd_v_o; resp_yumi_i only when resp_v_o; no push when full.
- Reset mid-operation: FIFO cleared immediately (async). In-flight target responses after reset are not forwarded.

Test Plan:
- Route: cmd addr 0x8000_1000 -> tgt_cmd_v_o=2'b01. Addr 0x0010_0000 (dev 1) -> 2'b10. Each response returned, outstanding_o 1 -> 0.
- Reorder: issue to tgt0 then tgt1; tgt1 asserts resp first -> resp_v_o=0 until tgt0 responds. Then tgt0 response delivered first, tgt1 next cycle.
- Full: max_outstanding_p=8, issue 8 cmds with no resp -> cmd_ready_o=0 on 9th. Pop one -> ready=1 next cycle; simultaneous pop at full still blocks the push.
- Unmapped: addr 0x0030_0000 (dev 3, map entry 0xF) -> routed to tgt0, unmapped_o=1 for exactly one cycle.
- Backpressure: tgt_cmd_ready_i[1]=0 with cmd to tgt1 -> cmd_ready_o=0, no push, outstanding_o unchanged.
- Reset: assert reset_n_i=0 with 3 outstanding -> outstanding_o=0, resp_v_o=0 immediately; normal operation resumes after release.
